// File: rtl/seg7_if.sv
// Peripheral-side bundle for the multiplexed 7-segment driver:
// CPU register inputs toward the driver, scanned display lines back out.
interface seg7_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   data_in;
  logic [DIGITS-1:0]     dp_in;
  logic                  lz_blank;
  logic                  enable;
  logic [6:0]            seg;
  logic                  dp;
  logic [DIGITS-1:0]     an;
  logic                  frame_done;

  modport master (
    output load, data_in, dp_in,
    output lz_blank, enable,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  load, data_in, dp_in,
    input  lz_blank, enable,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex display driver; new data is double-buffered
// and only swapped in at a frame boundary so digits never tear.
module seg7_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 100000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic   clk,
  input  logic   reset,
  seg7_if.slave  bus
);

  localparam int PW =
    (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW =
    (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [6:0] SEG_OFF =
    SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic DP_OFF =
    SEG_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [DIGITS-1:0] AN_OFF =
    AN_ACTIVE_LOW ? '1 : '0;

  logic [PW-1:0]            r_pcnt;
  logic [IW-1:0]            r_idx;
  logic [DIGITS-1:0][3:0]   r_act;
  logic [DIGITS-1:0][3:0]   r_pend;
  logic [DIGITS-1:0]        r_act_dp;
  logic [DIGITS-1:0]        r_pend_dp;
  logic                     r_pend_vld;

  logic [6:0]               r_seg;
  logic                     r_dp;
  logic [DIGITS-1:0]        r_an;
  logic                     r_fdone;

  logic                     w_tc;
  logic                     w_last;
  logic                     w_frame;
  logic [3:0]               w_nib;
  logic                     w_hi_nz;
  logic                     w_blank;
  logic [6:0]               w_seg;
  logic                     w_dp;
  logic [DIGITS-1:0]        w_an;

  function automatic logic [6:0] f_hex(
    input logic [3:0] n
  );
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    return s;
  endfunction

  assign w_tc    = (r_pcnt == PW'(SCAN_DIV - 1));
  assign w_last  = (r_idx == IW'(DIGITS - 1));
  assign w_frame = w_tc && w_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pcnt <= '0;
      r_idx  <= '0;
    end else begin
      r_pcnt <= w_tc ? '0 : r_pcnt + 1'b1;
      if (w_tc)
        r_idx <= w_last ? '0 : r_idx + 1'b1;
    end
  end

  // A load on the commit edge itself lands in pending for the next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_act      <= '0;
      r_act_dp   <= '0;
      r_pend     <= '0;
      r_pend_dp  <= '0;
      r_pend_vld <= 1'b0;
    end else begin
      if (bus.load) begin
        r_pend    <= bus.data_in;
        r_pend_dp <= bus.dp_in;
      end
      if (w_frame && r_pend_vld) begin
        r_act    <= r_pend;
        r_act_dp <= r_pend_dp;
      end
      if (bus.load)
        r_pend_vld <= 1'b1;
      else if (w_frame)
        r_pend_vld <= 1'b0;
    end
  end

  always_comb begin
    w_nib   = r_act[r_idx];
    w_hi_nz = 1'b0;
    for (int j = 0; j < DIGITS; j++) begin
      if (j >= int'(r_idx) && r_act[j] != 4'h0)
        w_hi_nz = 1'b1;
    end
    w_blank = bus.lz_blank &&
              (r_idx != '0) && !w_hi_nz;
    w_seg   = w_blank ? 7'h00 : f_hex(w_nib);
    w_dp    = r_act_dp[r_idx];
    w_an    = '0;
    w_an[r_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg   <= SEG_OFF;
      r_dp    <= DP_OFF;
      r_an    <= AN_OFF;
      r_fdone <= 1'b0;
    end else begin
      r_fdone <= w_frame;
      if (bus.enable) begin
        r_seg <= SEG_ACTIVE_LOW ? ~w_seg : w_seg;
        r_dp  <= SEG_ACTIVE_LOW ? ~w_dp : w_dp;
        r_an  <= AN_ACTIVE_LOW ? ~w_an : w_an;
      end else begin
        r_seg <= SEG_OFF;
        r_dp  <= DP_OFF;
        r_an  <= AN_OFF;
      end
    end
  end

  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.an         = r_an;
  assign bus.frame_done = r_fdone;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: stimulus queues per-cycle expected display words,
// a forked monitor pops and compares one word at each falling edge.
module tb_seg7_scan_driver;

  logic clk;
  logic reset;

  seg7_if #(.DIGITS(4)) bus ();

  seg7_scan_driver #(
    .DIGITS(4),
    .SCAN_DIV(4),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {an[3:0], seg[6:0], dp, frame_done}
  logic [12:0] q[$];
  int tests;
  int failed;

  function automatic logic [12:0] snap();
    return {bus.an, bus.seg, bus.dp, bus.frame_done};
  endfunction

  task automatic check(
    input string       name,
    input logic [12:0] got,
    input logic [12:0] exp
  );
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got an=%b seg=%h dp=%b fd=%b exp an=%b seg=%h dp=%b fd=%b",
        name, got[12:9], got[8:2], got[1], got[0],
        exp[12:9], exp[8:2], exp[1], exp[0]);
    end
  endtask

  task automatic monitor();
    logic [12:0] e;
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check($sformatf("scan%0d", n), snap(), e);
        n++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // s0..s3: expected active-low codes of digits 0..3 this frame;
  // dpx: lit decimal points; la/lb: load cycle (0 = none);
  // eo..ec: cycles with enable held low.
  task automatic frame(
    input logic [6:0]  s0, s1, s2, s3,
    input logic [3:0]  dpx,
    input bit          lz,
    input int          la,
    input logic [15:0] da,
    input logic [3:0]  pa,
    input int          lb,
    input logic [15:0] db,
    input logic [3:0]  pb,
    input int          eo,
    input int          ec
  );
    logic [6:0] s[4];
    logic [3:0] an;
    bit en;
    int t;
    s[0] = s0; s[1] = s1;
    s[2] = s2; s[3] = s3;
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 4; k++) begin
        t  = d * 4 + k + 1;
        en = !(t >= eo && t <= ec && eo > 0);
        an = 4'b0001 << d;
        if (en)
          q.push_back({~an, s[d], ~dpx[d], t == 16});
        else
          q.push_back({4'hF, 7'h7F, 1'b1, t == 16});
      end
    end
    bus.lz_blank = lz;
    for (int c = 1; c <= 16; c++) begin
      bus.load   = 1'b0;
      bus.enable = !(c >= eo && c <= ec && eo > 0);
      if (c == la) begin
        bus.load    = 1'b1;
        bus.data_in = da;
        bus.dp_in   = pa;
      end else if (c == lb) begin
        bus.load    = 1'b1;
        bus.data_in = db;
        bus.dp_in   = pb;
      end
      tick();
    end
    bus.load   = 1'b0;
    bus.enable = 1'b1;
  endtask

  localparam logic [12:0] RST_W =
    {4'hF, 7'h7F, 1'b1, 1'b0};

  initial begin
    tests  = 0;
    failed = 0;
    reset  = 1'b1;
    bus.load     = 1'b0;
    bus.data_in  = '0;
    bus.dp_in    = '0;
    bus.lz_blank = 1'b0;
    bus.enable   = 1'b1;
    fork
      monitor();
    join_none

    repeat (3) tick();
    check("reset_state", snap(), RST_W);

    @(negedge clk);
    #1 reset = 1'b0;

    // zeros, load 12AF mid-frame
    frame(7'h40, 7'h40, 7'h40, 7'h40, 4'h0, 1'b0,
          6, 16'h12AF, 4'h0, 0, 16'h0, 4'h0, 0, 0);
    // 12AF shown; two loads, last wins
    frame(7'h0E, 7'h08, 7'h24, 7'h79, 4'h0, 1'b0,
          3, 16'h1111, 4'h0, 9, 16'h2222, 4'h0, 0, 0);
    frame(7'h24, 7'h24, 7'h24, 7'h24, 4'h0, 1'b0,
          5, 16'h0050, 4'h0, 0, 16'h0, 4'h0, 0, 0);
    // 0050 with leading zeros blanked
    frame(7'h40, 7'h12, 7'h7F, 7'h7F, 4'h0, 1'b1,
          2, 16'h0000, 4'h8, 0, 16'h0, 4'h0, 0, 0);
    // 0000 blanked except digit0, dp on blank digit3;
    // 1234 pending, ABCD loaded on commit edge
    frame(7'h40, 7'h7F, 7'h7F, 7'h7F, 4'h8, 1'b1,
          4, 16'h1234, 4'h0, 16, 16'hABCD, 4'h0, 0, 0);
    frame(7'h19, 7'h30, 7'h24, 7'h79, 4'h0, 1'b1,
          0, 16'h0, 4'h0, 0, 16'h0, 4'h0, 0, 0);
    // ABCD shown, enable low for 10 cycles
    frame(7'h21, 7'h46, 7'h03, 7'h08, 4'h0, 1'b0,
          10, 16'h0050, 4'h1, 0, 16'h0, 4'h0, 3, 12);
    // lz off keeps zeros; pending 9999 then reset
    frame(7'h40, 7'h12, 7'h40, 7'h40, 4'h1, 1'b0,
          8, 16'h9999, 4'hF, 0, 16'h0, 4'h0, 0, 0);

    bus.load    = 1'b1;
    bus.data_in = 16'h8888;
    tick();
    bus.load = 1'b0;
    repeat (2) tick();
    #2 reset = 1'b1;
    #1 check("async_reset", snap(), RST_W);
    repeat (2) tick();
    check("reset_hold", snap(), RST_W);
    @(negedge clk);
    #1 reset = 1'b0;

    // both active and pending were discarded
    frame(7'h40, 7'h40, 7'h40, 7'h40, 4'h0, 1'b0,
          0, 16'h0, 4'h0, 0, 16'h0, 4'h0, 0, 0);
    frame(7'h40, 7'h40, 7'h40, 7'h40, 4'h0, 1'b0,
          0, 16'h0, 4'h0, 0, 16'h0, 4'h0, 0, 0);

    @(negedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      failed++;
      $display("FAIL drain got=%0d left exp=0",
        q.size());
    end

    $display("[TB] %0d tests run, %0d failed",
      tests, failed);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed 7-segment display driver for the board peripheral bus. It takes a packed vector of hex nibbles plus decimal points from the CPU-side peripheral register, and buffers updates so they apply only at a frame boundary. It scans DIGITS common-anode/cathode digits with a programmable dwell, decoding each nibble to segments internally with optional leading-zero suppression. It supersedes per-digit combinational decoders.

## Interface
- DIGITS, 4, number of digits scanned (1..8); digit 0 is rightmost
- SCAN_DIV, 100000, clk cycles each digit is driven (>=1)
- SEG_ACTIVE_LOW, 1, 1: seg/dp driven low to light
- AN_ACTIVE_LOW, 1, 1: an driven low to select

- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- load  input  1  capture data_in/dp_in into pending buffer this cycle
- data_in  input  4*DIGITS  nibble i at [4i+3:4i] for digit i
- dp_in  input  DIGITS  decimal point per digit, 1 = lit
- lz_blank  input  1  1: suppress leading zeros
- enable  input  1  0: all anodes inactive, scanning continues
- seg  output  7  segments {g,f,e,d,c,b,a}, registered
- dp  output  1  decimal point for selected digit, registered
- an  output  DIGITS  one-hot digit select, registered
- frame_done  output  1  one-cycle pulse at each frame commit edge

## Operation
- Prescaler pcnt counts 0..SCAN_DIV-1; terminal count (tc) when pcnt==SCAN_DIV-1, then wraps to 0.
- Digit index idx advances on tc; wraps DIGITS-1 -> 0. Frame edge = tc with idx==DIGITS-1.
- Buffering: load writes pending_data/pending_dp and sets pending_valid; a later load before commit overwrites (last wins).
- Commit on frame edge: if pending_valid, active <= pending, pending_valid <= 0; else active unchanged. frame_done pulses on every frame edge.
- load on the commit edge itself: commit uses pre-edge pending contents; the new load becomes pending with pending_valid=1 for next frame.
- Decode (active-high, {g..a}): 0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 07, 8 7F, 9 6F, A 77, b 7C, C 39, d 5E, E 79, F 71.
- Leading-zero suppression: digit i (i>0) is blanked (seg code 00, dp still honoured) when lz_blank=1 and active nibbles i..DIGITS-1 are all zero. Digit 0 is never blanked.
- Polarity applied last: seg/dp inverted if SEG_ACTIVE_LOW; an inverted if AN_ACTIVE_LOW.
- enable=0: an all inactive, seg/dp inactive; pcnt, idx and commit logic unaffected.

## Timing
- Reset (async assert, sync to clk edge on release): pcnt=0, idx=0, active data/dp=0, pending_valid=0, seg/dp all inactive level, an all inactive, frame_done=0.
- Outputs registered from current idx/active: one-cycle latency; first edge after reset release drives an[0] (if enable) with digit 0 of active (all zeros -> code 3F).
- Each digit held exactly SCAN_DIV cycles; frame = DIGITS*SCAN_DIV cycles.
- Committed data appears on seg one cycle after frame edge, starting with digit 0.
- Worst-case load-to-display: DIGITS*SCAN_DIV+1 cycles; no digit ever shows a mix of old and new frames.
- SCAN_DIV=1: idx advances every cycle; DIGITS=1: every tc is a frame edge.
- Reset mid-frame discards pending and active immediately.

## Test plan
- DIGITS=4, SCAN_DIV=4, AN/SEG active-low, enable=1, after reset: an cycles 1110,1101,1011,0111 each 4 cycles; seg=~3F=40 throughout; frame_done every 16 cycles.
- load data_in=16'h12AF mid-frame: display unchanged until next frame_done, then digit0 seg=~71, digit1 ~77, digit2 ~5B, digit3 ~06.
- Two loads (16'h1111 then 16'h2222) in one frame: only 2222 displayed after commit, 1111 never appears.
- lz_blank=1, data 16'h0050: digits 3,2 seg=7F (blank, active-low), digit1 ~6D, digit0 ~3F; data 16'h0000 shows only digit0 "0".
- load asserted on frame-edge cycle with 16'hABCD while pending 16'h1234: next frame shows 1234, following frame shows ABCD.
- enable=0 for 10 cycles then 1: an=1111 while low; scan position continues as if uninterrupted; reset asserted mid-frame returns all outputs to reset values asynchronously.
